// File: rtl/t2b_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : t2b_decoder_if
//  Description : Input/output handshake bundle of the thermometer-to-binary
//                decoder. The slave side is the decoder; the master side is the
//                producer/consumer environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface t2b_decoder_if #(
    parameter int BIN_WIDTH   = 3,
    parameter int THERM_WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [THERM_WIDTH-1:0] therm_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [BIN_WIDTH-1:0]   bin_out;
    logic                   bubble_err;
    logic                   underflow;
    logic                   cnt_clr;
    logic [7:0]             bubble_cnt;

    modport slave (
        input  in_valid, therm_in, out_ready, cnt_clr,
        output in_ready, out_valid, bin_out, bubble_err, underflow, bubble_cnt
    );

    modport master (
        output in_valid, therm_in, out_ready, cnt_clr,
        input  in_ready, out_valid, bin_out, bubble_err, underflow, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/t2b_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : t2b_decoder
//  Description : Two-stage pipelined thermometer-to-binary decoder with bubble
//                detection, saturating bubble counter and valid/ready flow.
//                Define T2B_BUBBLE_CORR_EN to enable 3-input majority bubble
//                correction ahead of the priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module t2b_decoder #(
    parameter int BIN_WIDTH   = 3,
    parameter int THERM_WIDTH = 8   // must equal 2**BIN_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        rst,
    t2b_decoder_if.slave     bus
);

    localparam logic [7:0] c_cnt_max = 8'hFF;

    // Stage S1: raw word
    logic                   r_s1_valid;
    logic [THERM_WIDTH-1:0] r_s1_word;

    // Stage S2: decode result
    logic                   r_out_valid;
    logic [BIN_WIDTH-1:0]   r_bin_out;
    logic                   r_bubble_err;
    logic                   r_underflow;
    logic [7:0]             r_bubble_cnt;

    logic                   w_s2_adv;
    logic                   w_in_ready;
    logic                   w_out_xfer;
    logic [THERM_WIDTH-1:0] w_corr;
    logic [BIN_WIDTH-1:0]   w_enc;
    logic                   w_underflow;
    logic                   w_bubble;

    assign w_s2_adv   = !r_out_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_adv;
    assign w_out_xfer = r_out_valid && bus.out_ready;

    // Legal codes are 2**k-1 with k>=1, i.e. nonzero and w & (w+1) == 0.
    assign w_bubble = (|r_s1_word) &&
                      (|(r_s1_word & (r_s1_word + THERM_WIDTH'(1))));

`ifdef T2B_BUBBLE_CORR_EN
    logic [THERM_WIDTH+1:0] w_ext;
    assign w_ext = {1'b0, r_s1_word, 1'b1};

    for (genvar gi = 0; gi < THERM_WIDTH; gi++) begin : g_corr
        assign w_corr[gi] = (w_ext[gi]   & w_ext[gi+1]) |
                            (w_ext[gi]   & w_ext[gi+2]) |
                            (w_ext[gi+1] & w_ext[gi+2]);
    end
`else
    assign w_corr = r_s1_word;
`endif

    always_comb begin
        w_enc = '0;
        for (int i = 0; i < THERM_WIDTH; i++) begin
            if (w_corr[i]) begin
                w_enc = BIN_WIDTH'(i);
            end
        end
    end

    assign w_underflow = ~|w_corr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_word  <= '0;
        end else if (w_in_ready) begin
            // When S1 is being drained and nothing arrives it empties.
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_word <= bus.therm_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_bin_out    <= '0;
            r_bubble_err <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_bin_out    <= w_enc;
                r_bubble_err <= w_bubble;
                r_underflow  <= w_underflow;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_bubble_cnt <= '0;
        end else if (w_out_xfer && r_bubble_err && (r_bubble_cnt != c_cnt_max)) begin
            r_bubble_cnt <= r_bubble_cnt + 8'd1;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.bin_out    = r_bin_out;
    assign bus.bubble_err = r_bubble_err;
    assign bus.underflow  = r_underflow;
    assign bus.bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_t2b_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_t2b_decoder
//  Description : Scoreboard testbench for t2b_decoder (8-bit thermometer).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_t2b_decoder;

    typedef struct packed {
        logic [2:0] bin;
        logic       bub;
        logic       unf;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   cyc;
    int   total;
    int   bad;

    t2b_decoder_if #(.BIN_WIDTH(3), .THERM_WIDTH(8)) bus ();

    t2b_decoder #(.BIN_WIDTH(3), .THERM_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Reference decode of one 8-bit word.
    function automatic exp_t model(input logic [7:0] w);
        exp_t       r;
        logic       legal;
        logic [9:0] t;
        logic [7:0] c;
        logic [8:0] code;
        legal = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            code = (9'd1 << k) - 9'd1;
            if (w == code[7:0]) legal = 1'b1;
        end
        r.bub = (w != 8'd0) && !legal;
`ifdef T2B_BUBBLE_CORR_EN
        t = {1'b0, w, 1'b1};
        for (int i = 0; i < 8; i++) begin
            c[i] = ((32'(t[i]) + 32'(t[i+1]) + 32'(t[i+2])) >= 2);
        end
`else
        t = '0;
        c = w;
`endif
        r.unf = (c == 8'd0);
        r.bin = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) r.bin = 3'(i);
        end
        r.cyc = 0;
        return r;
    endfunction

    // One clock: record accepts into the scoreboard and report any output transfer.
    task automatic tick(output logic xf, output logic [2:0] b, output logic be,
                        output logic uf, output int oc);
        exp_t e;
        @(negedge clk);
        if (bus.in_valid && bus.in_ready) begin
            e     = model(bus.therm_in);
            e.cyc = cyc;
            sb.push_back(e);
        end
        xf = bus.out_valid && bus.out_ready;
        b  = bus.bin_out;
        be = bus.bubble_err;
        uf = bus.underflow;
        oc = cyc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.bin_out !== 3'd0) begin bad++; $display("FAIL reset_bin_out got=%0d want=0", bus.bin_out); end
        total++; if ({bus.bubble_err, bus.underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {bus.bubble_err, bus.underflow}); end
        total++; if (bus.bubble_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.bubble_cnt); end
    endtask

    task automatic test_sweep();
        logic x, be, uf; logic [2:0] b; int oc; exp_t e; logic [8:0] w;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 14; n++) begin
            w = (9'd1 << (n + 1)) - 9'd1;
            bus.in_valid = (n < 8);
            bus.therm_in = w[7:0];
            tick(x, b, be, uf, oc);
            if (x) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL sweep_spurious got bin=%0d want=no output", b);
                end else begin
                    e = sb.pop_front();
                    if ({b, be, uf} !== {e.bin, e.bub, e.unf}) begin
                        bad++; $display("FAIL sweep_data got=%0d/%b/%b want=%0d/%b/%b", b, be, uf, e.bin, e.bub, e.unf);
                    end
                    total++;
                    if (oc - e.cyc != 2) begin
                        bad++; $display("FAIL sweep_latency got=%0d want=2", oc - e.cyc);
                    end
                end
            end
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sweep_drain got=%0d pending want=0", sb.size()); end
    endtask

    task automatic test_bubble();
        logic x, be, uf; logic [2:0] b; int oc; exp_t e;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            bus.in_valid = (n == 0);
            bus.therm_in = 8'b0001_0111;
            tick(x, b, be, uf, oc);
            if (x) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL bubble_spurious got bin=%0d want=no output", b);
                end else begin
                    e = sb.pop_front();
                    if ({b, be, uf} !== {e.bin, e.bub, e.unf}) begin
                        bad++; $display("FAIL bubble_data got=%0d/%b/%b want=%0d/%b/%b", b, be, uf, e.bin, e.bub, e.unf);
                    end
`ifndef T2B_BUBBLE_CORR_EN
                    total++;
                    if (b !== 3'd4) begin bad++; $display("FAIL bubble_raw_bin got=%0d want=4", b); end
`endif
                end
            end
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL bubble_drain got=%0d pending want=0", sb.size()); end
        total++; if (bus.bubble_cnt !== 8'd1) begin bad++; $display("FAIL bubble_cnt got=%0d want=1", bus.bubble_cnt); end
    endtask

    task automatic test_underflow();
        logic x, be, uf; logic [2:0] b; int oc; exp_t e;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            bus.in_valid = (n == 0);
            bus.therm_in = 8'h00;
            tick(x, b, be, uf, oc);
            if (x) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL underflow_spurious got bin=%0d want=no output", b);
                end else begin
                    e = sb.pop_front();
                    if ({b, be, uf} !== {3'd0, 1'b0, 1'b1} || {b, be, uf} !== {e.bin, e.bub, e.unf}) begin
                        bad++; $display("FAIL underflow_data got=%0d/%b/%b want=0/0/1", b, be, uf);
                    end
                end
            end
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL underflow_drain got=%0d pending want=0", sb.size()); end
    endtask

    task automatic test_backpressure();
        logic x, be, uf; logic [2:0] b; int oc; exp_t e;
        logic [7:0] words [3];
        logic [2:0] held;
        int idx, nx, last;
        words[0] = 8'b0000_0011; words[1] = 8'b0000_1111; words[2] = 8'b0111_1111;
        idx = 0; nx = 0; last = -10;
        held = 3'd0;
        bus.out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            bus.in_valid = (idx < 3);
            bus.therm_in = words[idx % 3];
            tick(x, b, be, uf, oc);
            if (sb.size() > idx) idx++;
            if (n == 2) held = bus.bin_out;
        end
        total++; if (idx != 2) begin bad++; $display("FAIL bp_accepts got=%0d want=2", idx); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%b want=1", bus.out_valid); end
        total++; if (bus.bin_out !== held || held !== 3'd1) begin bad++; $display("FAIL bp_hold got=%0d was=%0d want=1", bus.bin_out, held); end
        bus.out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            bus.in_valid = (idx < 3);
            bus.therm_in = words[idx % 3];
            tick(x, b, be, uf, oc);
            if (bus.in_valid && sb.size() + nx > idx) idx++;
            if (x) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL bp_spurious got bin=%0d want=no output", b);
                end else begin
                    e = sb.pop_front();
                    if ({b, be, uf} !== {e.bin, e.bub, e.unf}) begin
                        bad++; $display("FAIL bp_data got=%0d/%b/%b want=%0d/%b/%b", b, be, uf, e.bin, e.bub, e.unf);
                    end
                end
                if (nx > 0) begin
                    total++;
                    if (oc != last + 1) begin bad++; $display("FAIL bp_consecutive got gap=%0d want=1", oc - last); end
                end
                last = oc;
                nx++;
            end
        end
        total++; if (nx != 3 || sb.size() != 0) begin bad++; $display("FAIL bp_count got=%0d pending=%0d want=3/0", nx, sb.size()); end
    endtask

    task automatic test_counter();
        logic x, be, uf; logic [2:0] b; int oc; exp_t e;
        logic [7:0] bw [3];
        bw[0] = 8'b0001_0111; bw[1] = 8'b0000_0101; bw[2] = 8'b1000_0001;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 306; n++) begin
            bus.in_valid = (n < 300);
            bus.therm_in = bw[n % 3];
            tick(x, b, be, uf, oc);
            if (x) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL cnt_spurious got bin=%0d want=no output", b);
                end else begin
                    e = sb.pop_front();
                    if ({b, be, uf} !== {e.bin, e.bub, e.unf}) begin
                        bad++; $display("FAIL cnt_data got=%0d/%b/%b want=%0d/%b/%b", b, be, uf, e.bin, e.bub, e.unf);
                    end
                end
            end
        end
        total++; if (bus.bubble_cnt !== 8'd255) begin bad++; $display("FAIL cnt_saturate got=%0d want=255", bus.bubble_cnt); end
        bus.in_valid = 1'b1;
        bus.therm_in = 8'b0001_0111;
        tick(x, b, be, uf, oc);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5 && !bus.out_valid; k++) tick(x, b, be, uf, oc);
        total++;
        if (!bus.out_valid) begin
            bad++; $display("FAIL cnt_clr_wait got out_valid=0 want=1 within 5 cycles");
        end else begin
            bus.cnt_clr = 1'b1;
            tick(x, b, be, uf, oc);
            bus.cnt_clr = 1'b0;
            if (!x || !be || sb.size() == 0) begin
                bad++; $display("FAIL cnt_clr_xfer got xfer=%b err=%b want=1/1", x, be);
            end else begin
                e = sb.pop_front();
            end
            total++; if (bus.bubble_cnt !== 8'd0) begin bad++; $display("FAIL cnt_clr got=%0d want=0", bus.bubble_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        logic x, be, uf; logic [2:0] b; int oc;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            bus.in_valid = (n == 0);
            bus.therm_in = 8'b0000_0101;
            tick(x, b, be, uf, oc);
            if (x && sb.size() > 0) void'(sb.pop_front());
        end
        total++; if (bus.bubble_cnt !== 8'd1) begin bad++; $display("FAIL rst_pre_cnt got=%0d want=1", bus.bubble_cnt); end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.therm_in  = 8'b0011_1111;
        for (int n = 0; n < 3; n++) tick(x, b, be, uf, oc);
        total++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin bad++; $display("FAIL rst_pre_full got=%b want=10", {bus.out_valid, bus.in_ready}); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.bubble_cnt !== 8'd0) begin bad++; $display("FAIL rst_async_cnt got=%0d want=0", bus.bubble_cnt); end
        sb.delete();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", bus.in_ready); end
        for (int n = 0; n < 8; n++) begin
            tick(x, b, be, uf, oc);
            total++;
            if (x !== 1'b0) begin bad++; $display("FAIL rst_stale got bin=%0d want=no output", b); end
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.therm_in  = 8'h00;
        bus.out_ready = 1'b0;
        bus.cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_sweep();
        test_bubble();
        test_underflow();
        test_backpressure();
        test_counter();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
